// File: rtl/bk_pkg.sv
// rtl/bk_pkg.sv - shared Brent-Kung arithmetic types, default width and prefix depth
package bk_pkg;

  localparam int BK_WIDTH = 12;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  function automatic int bk_depth(input int width);
    for (int d = 0; d < 31; d++) begin
      if ((1 << d) >= width) return d;
    end
    return 31;
  endfunction

endpackage

// File: rtl/bk_sub_pipe_if.sv
// rtl/bk_sub_pipe_if.sv - operand/result handshake bundle for bk_sub_pipe
interface bk_sub_pipe_if import bk_pkg::*; #(
  parameter int WIDTH = BK_WIDTH
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_diff;
  logic             out_borrow;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_diff, out_borrow
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_diff, out_borrow
  );
endinterface

// File: rtl/bk_gp_cell.sv
// rtl/bk_gp_cell.sv - (G,P) group combine, high group over low group
module bk_gp_cell import bk_pkg::*; (
  input  gp_t hi,
  input  gp_t lo,
  output gp_t o
);
  assign o.g = hi.g | (hi.p & lo.g);
  assign o.p = hi.p & lo.p;
endmodule

// File: rtl/bk_sub_pipe.sv
// rtl/bk_sub_pipe.sv - 3-stage Brent-Kung subtractor a-b with borrow and valid/ready
// BK_SUB_SATURATE_EN: clamp out_diff to zero whenever a borrow occurs.
module bk_sub_pipe import bk_pkg::*; #(
  parameter int WIDTH = BK_WIDTH
) (
  input logic         clk,
  input logic         rst,
  bk_sub_pipe_if.slave bus
);
  localparam int D = bk_depth(WIDTH);
  localparam int N = 1 << D;

  logic v1, v2, v3;
  logic rdy2, rdy3, load1, load2, load3;

  assign rdy3         = ~v3 | bus.out_ready;
  assign rdy2         = ~v2 | rdy3;
  assign bus.in_ready = ~v1 | rdy2;
  assign load1        = bus.in_valid & bus.in_ready;
  assign load2        = v1 & rdy2;
  assign load3        = v2 & rdy3;
  assign bus.out_valid = v3;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else begin
      v1 <= load1 | (v1 & ~rdy2);
      v2 <= load2 | (v2 & ~rdy3);
      v3 <= load3 | (v3 & ~bus.out_ready);
    end
  end

  logic [WIDTH-1:0] s1_g, s1_p, s2_p;
  gp_t  [N-1:0]     up0, up_top, s2_gp, pre;

  always_ff @(posedge clk) begin
    if (load1) begin
      s1_g <= bus.in_a & ~bus.in_b;
      s1_p <= bus.in_a ^ ~bus.in_b;
    end
  end

  // Carry-in of 1 is absorbed into bit 0 so every prefix G is directly a carry.
  always_comb begin
    up0 = '0;
    for (int k = 0; k < WIDTH; k++) begin
      up0[k].g = s1_g[k];
      up0[k].p = s1_p[k];
    end
    up0[0].g = s1_g[0] | s1_p[0];
  end

  genvar l, k, j;
  for (l = 1; l <= D; l++) begin : up
    gp_t [N-1:0] prev, node;
    if (l == 1) begin : g_first
      assign prev = up0;
    end else begin : g_chain
      assign prev = up[l-1].node;
    end
    for (k = 0; k < N; k++) begin : nd
      if (((k + 1) % (1 << l)) == 0) begin : g_cell
        bk_gp_cell u_cell (.hi(prev[k]), .lo(prev[k - (1 << (l - 1))]), .o(node[k]));
      end else begin : g_pass
        assign node[k] = prev[k];
      end
    end
  end

  if (D >= 1) begin : g_up_top
    assign up_top = up[D].node;
  end else begin : g_up_none
    assign up_top = up0;
  end

  always_ff @(posedge clk) begin
    if (load2) begin
      s2_gp <= up_top;
      s2_p  <= s1_p;
    end
  end

  for (j = 0; j < D - 1; j++) begin : dn
    localparam int L = D - 1 - j;
    localparam int H = 1 << (L - 1);
    gp_t [N-1:0] prev, node;
    if (j == 0) begin : g_first
      assign prev = s2_gp;
    end else begin : g_chain
      assign prev = dn[j-1].node;
    end
    for (k = 0; k < N; k++) begin : nd
      if ((((k + 1) % (1 << L)) == H) && (k >= (1 << L))) begin : g_cell
        bk_gp_cell u_cell (.hi(prev[k]), .lo(prev[k - H]), .o(node[k]));
      end else begin : g_pass
        assign node[k] = prev[k];
      end
    end
  end

  if (D >= 2) begin : g_pre
    assign pre = dn[D-2].node;
  end else begin : g_pre_none
    assign pre = s2_gp;
  end

  logic             unused_pre;
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] diff_raw, diff_n;
  logic             borrow_n;

  assign unused_pre = ^pre;

  always_comb begin
    carry    = '0;
    carry[0] = 1'b1;
    for (int i = 0; i < WIDTH; i++) carry[i+1] = pre[i].g;
    diff_raw = s2_p ^ carry[WIDTH-1:0];
    borrow_n = ~carry[WIDTH];
`ifdef BK_SUB_SATURATE_EN
    diff_n = borrow_n ? '0 : diff_raw;
`else
    diff_n = diff_raw;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_diff   <= '0;
      bus.out_borrow <= 1'b0;
    end else if (load3) begin
      bus.out_diff   <= diff_n;
      bus.out_borrow <= borrow_n;
    end
  end
endmodule

// File: tb/tb_bk_sub_pipe.sv
// tb/tb_bk_sub_pipe.sv - self-checking bench for bk_sub_pipe against an arithmetic reference queue
module tb_bk_sub_pipe;
  import bk_pkg::*;
  localparam int W = BK_WIDTH;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bk_sub_pipe_if #(.WIDTH(W)) bus ();
  bk_sub_pipe #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;
  int accepted = 0;
  int drained  = 0;
  bit rand_valid = 0;
  bit rand_ready = 0;
  logic [W-1:0] src_a[$];
  logic [W-1:0] src_b[$];
  logic [W:0]   exp_q[$];

  function automatic logic [W:0] ref_sub(input logic [W-1:0] a, input logic [W-1:0] b);
    int d;
    bit br;
    d  = int'(a) - int'(b);
    br = (d < 0);
    if (br) begin
`ifdef BK_SUB_SATURATE_EN
      d = 0;
`else
      d = d + (1 << W);
`endif
    end
    return {br, d[W-1:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_next();
    if (src_a.size() > 0 && (!rand_valid || $urandom_range(0, 3) != 0)) begin
      bus.in_valid = 1'b1;
      bus.in_a     = src_a[0];
      bus.in_b     = src_b[0];
    end else begin
      bus.in_valid = 1'b0;
      bus.in_a     = W'($urandom);
      bus.in_b     = W'($urandom);
    end
    if (rand_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic push(input logic [W-1:0] a, input logic [W-1:0] b);
    src_a.push_back(a);
    src_b.push_back(b);
  endtask

  task automatic tick();
    logic [W:0] e;
    #1;
    if (!rst) begin
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(ref_sub(bus.in_a, bus.in_b));
        void'(src_a.pop_front());
        void'(src_b.pop_front());
        accepted++;
      end
      if (bus.out_valid && bus.out_ready) begin
        drained++;
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 32'(bus.out_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("out_diff", 32'(bus.out_diff), 32'(e[W-1:0]));
          chk("out_borrow", 32'(bus.out_borrow), 32'(e[W]));
        end
      end
    end
    @(posedge clk);
    #1;
    drive_next();
  endtask

  initial begin
    int a0, d0;
    logic [W-1:0] sat_or_wrap;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_out_diff", 32'(bus.out_diff), 32'd0);
    chk("reset_out_borrow", 32'(bus.out_borrow), 32'd0);

    bus.out_ready = 1'b1;
    push(12'h005, 12'h003);
    drive_next();
    tick();
    chk("lat_cycle1_valid", 32'(bus.out_valid), 32'd0);
    tick();
    chk("lat_cycle2_valid", 32'(bus.out_valid), 32'd0);
    tick();
    chk("lat_cycle3_valid", 32'(bus.out_valid), 32'd1);
    chk("basic_diff", 32'(bus.out_diff), 32'h002);
    chk("basic_borrow", 32'(bus.out_borrow), 32'd0);
    tick();

`ifdef BK_SUB_SATURATE_EN
    sat_or_wrap = 12'h000;
`else
    sat_or_wrap = 12'hFFF;
`endif
    push(12'h000, 12'h001);
    drive_next();
    repeat (3) tick();
    chk("under_valid", 32'(bus.out_valid), 32'd1);
    chk("under_diff", 32'(bus.out_diff), 32'(sat_or_wrap));
    chk("under_borrow", 32'(bus.out_borrow), 32'd1);
    tick();

    push(12'hFFF, 12'hFFF);
    push(12'h800, 12'h7FF);
    drive_next();
    repeat (3) tick();
    chk("b2b_first_valid", 32'(bus.out_valid), 32'd1);
    chk("b2b_first_diff", 32'(bus.out_diff), 32'h000);
    chk("b2b_first_borrow", 32'(bus.out_borrow), 32'd0);
    tick();
    chk("b2b_second_valid", 32'(bus.out_valid), 32'd1);
    chk("b2b_second_diff", 32'(bus.out_diff), 32'h001);
    chk("b2b_second_borrow", 32'(bus.out_borrow), 32'd0);
    repeat (2) tick();

    bus.out_ready = 1'b0;
    a0 = accepted;
    d0 = drained;
    for (int i = 0; i < 5; i++) push(W'(12'h100 * i + 7), W'(12'h0F0 * i + 3));
    drive_next();
    repeat (6) tick();
    chk("stall_accepts", 32'(accepted - a0), 32'd3);
    chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("stall_valid", 32'(bus.out_valid), 32'd1);
      chk("stall_diff_hold", 32'(bus.out_diff), 32'(exp_q[0][W-1:0]));
      chk("stall_borrow_hold", 32'(bus.out_borrow), 32'(exp_q[0][W]));
      tick();
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 30 && (drained - d0) < 5; i++) tick();
    chk("stall_drain_count", 32'(drained - d0), 32'd5);
    chk("stall_accept_total", 32'(accepted - a0), 32'd5);

    push(12'h123, 12'h045);
    push(12'h010, 12'h200);
    drive_next();
    tick();
    tick();
    chk("flight_not_out", 32'(bus.out_valid), 32'd0);
    rst = 1'b1;
    exp_q.delete();
    src_a.delete();
    src_b.delete();
    tick();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    rst = 1'b0;
    d0 = drained;
    repeat (6) tick();
    chk("rst_no_emit", 32'(drained - d0), 32'd0);
    chk("rst_idle_valid", 32'(bus.out_valid), 32'd0);

    for (int i = 0; i < 10000; i++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom);
      rb = ($urandom_range(0, 15) == 0) ? ra : W'($urandom);
      push(ra, rb);
    end
    rand_valid = 1'b1;
    rand_ready = 1'b1;
    a0 = accepted;
    d0 = drained;
    drive_next();
    for (int i = 0; i < 60000 && (drained - d0) < 10000; i++) tick();
    rand_valid = 1'b0;
    rand_ready = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) tick();
    chk("rand_accepted", 32'(accepted - a0), 32'd10000);
    chk("rand_drained", 32'(drained - d0), 32'd10000);
    chk("rand_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bk_sub_pipe.md
# bk_sub_pipe

Pipelined WIDTH-bit Brent-Kung prefix subtractor with a valid/ready handshake. It is the inverse-direction companion of the combinational Brent-Kung adder in the same arithmetic library. It computes `a - b` as `a + ~b + 1` through a registered generate/propagate, up-sweep and down-sweep, and reports a borrow flag. It sits between an operand producer and a result consumer that may stall.

## Interface
- `WIDTH`, default 12: operand and difference width; must be a power of two or 12 (a prefix tree over a non-power-of-two width pads to the next power of two internally).
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  reset; **synchronous, active-high**.
- `in_valid`  in  1  operands present.
- `in_ready`  out  1  block accepts operands this cycle.
- `in_a`  in  WIDTH  minuend, unsigned.
- `in_b`  in  WIDTH  subtrahend, unsigned.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  consumer accepts result this cycle.
- `out_diff`  out  WIDTH  `(a - b) mod 2^WIDTH`, or the clamped value when saturation is compiled in.
- `out_borrow`  out  1  1 iff `a < b` unsigned; equals the inverted carry-out of `a + ~b + 1`.

## Operation
- Transfer on a port occurs only in a cycle where valid and ready are both 1.
- Stage S1 registers, per bit: `g_i = a_i & ~b_i` and `p_i = a_i ^ ~b_i`. The initial carry-in is constant 1, folded in as bit −1 generate.
- Stage S2 registers the Brent-Kung up-sweep group (G,P) at spans 2, 4, 8, … and keeps the bit-level p.
- Stage S3 completes the down-sweep and registers the result:
  - `diff_i = p_i ^ c_i`
  - `out_borrow = ~c_WIDTH`
- Each stage holds one valid bit plus payload. A stage loads when it is empty or when its contents advance in the same cycle.
- `in_ready = ~v1 | (~v2 | (~v3 | out_ready))`, computed combinationally through the chain. There is no bubble, so the block sustains one operation per cycle under continuous `out_ready`.
- When `out_ready` = 0 and S3 is full, S3 holds. Upstream stages hold once they are full.
- Results appear in acceptance order. No reordering and no drops.
- Arithmetic is unsigned and modular. Width rule: the internal carry is WIDTH+1 bits; no other widening.

## Timing
- Reset: all stage valid bits = 0, `out_valid` = 0, `out_diff` = 0, `out_borrow` = 0. `in_ready` = 1 in the first cycle after reset deasserts.
- Latency: an accept in cycle N gives `out_valid` = 1 in cycle N+3, provided there are no downstream stalls.
- Full occupancy: 3 results in flight. A 4th accept is possible only in a cycle where `out_ready` = 1.
- Simultaneous accept at the input and drain at the output in the same cycle: both occur, and occupancy is unchanged.
- `out_diff` and `out_borrow` stay stable while `out_valid` = 1 and `out_ready` = 0.
- `rst` asserted mid-operation: all in-flight results are discarded at the next edge. There is no partial output.
- `in_a` and `in_b` are don't-care while `in_valid` = 0. Payload registers load only on transfer.

## Configuration
- `BK_SUB_SATURATE_EN` defined: when the borrow is 1, `out_diff` = 0, i.e. a clamped unsigned subtract. `out_borrow` is still reported.
- `BK_SUB_SATURATE_EN` not defined: `out_diff` is the modular wraparound value.
- Latency and handshake are identical in both builds.

## Structure
- Shared package `bk_pkg` holds:
  - `BK_WIDTH` (12)
  - `gp_t` (struct with g and p bits)
  - the function returning prefix depth `log2ceil(WIDTH)`
- The adder variants reuse `bk_pkg`.
- One sub-module, `bk_gp_cell`: the (G,P) combine `G = Gh | (Ph & Gl)`, `P = Ph & Pl`. It is instantiated in both the up-sweep and the down-sweep.
- The pipeline control (three valid bits and their load enables) lives in the top module.

## Test plan
- Reset, then `a`=0x005, `b`=0x003 with `out_ready` = 1 → 3 cycles later `diff`=0x002, `borrow`=0.
- `a`=0x000, `b`=0x001 → `diff`=0xFFF, `borrow`=1. With `BK_SUB_SATURATE_EN`: `diff`=0x000, `borrow`=1.
- `a`=0xFFF, `b`=0xFFF, then `a`=0x800, `b`=0x7FF, back-to-back → `diff` 0x000 / `borrow` 0, then 0x001 / 0, on consecutive cycles.
- Stream 5 operations with `out_ready` = 0 → exactly 3 accepted and `in_ready` falls. Raise `out_ready` → results drain in order, values unchanged while stalled.
- Assert `rst` with 2 results in flight → `out_valid` = 0 the next cycle. Those results are never emitted.
- Random 10k pairs with random valid/ready → every result equals a reference `a - b` and `a < b`, in order, with no loss.
